// File: rtl/snake_tile_renderer.sv
// Snake game tile renderer: HPS command FIFO, palette/score registers and a
// pixel engine that expands grid cells (or a whole-screen checkerboard clear)
// into Avalon pixel-master writes.
module snake_tile_renderer #(
  parameter int unsigned GRID_W      = 40,
  parameter int unsigned GRID_H      = 30,
  parameter int unsigned CELL_LOG2   = 3,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] VGA_PX_BASE = 32'h0800_0000,
  parameter int unsigned X_SHIFT     = 1,
  parameter int unsigned Y_SHIFT     = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  hps_address,
  input  logic        hps_read,
  input  logic        hps_write,
  input  logic [31:0] hps_writedata,
  output logic [31:0] hps_readdata,
  output logic        hps_waitrequest,
  output logic [31:0] vga_px_address,
  output logic        vga_px_write,
  output logic [15:0] vga_px_writedata,
  input  logic        vga_px_waitrequest,
  output logic [1:0]  state_export,
  output logic [15:0] score_out
);

  localparam int unsigned CELL_PX    = 1 << CELL_LOG2;
  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT   = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] CELL_LAST  = 16'(CELL_PX - 1);
  localparam logic [15:0] CLR_X_LAST = 16'(GRID_W * CELL_PX - 1);
  localparam logic [15:0] CLR_Y_LAST = 16'(GRID_H * CELL_PX - 1);
  localparam logic [7:0]  GRID_W8    = 8'(GRID_W);
  localparam logic [7:0]  GRID_H8    = 8'(GRID_H);

  localparam logic [3:0] OP_START = 4'h1;
  localparam logic [3:0] OP_END   = 4'h2;
  localparam logic [3:0] OP_FILL  = 4'h3;
  localparam logic [3:0] OP_ERASE = 4'h4;
  localparam logic [3:0] OP_SCORE = 4'h5;
  localparam logic [3:0] OP_SOFT  = 4'hF;

  typedef enum logic [1:0] {
    WAITING = 2'd0,
    PLAYING = 2'd1,
    FILL    = 2'd2,
    CLEAR   = 2'd3
  } state_t;

  state_t      state, ret_state;
  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [15:0] pal [4];
  logic [15:0] bg_a, bg_b, score, fill_colour;
  logic        err;
  logic [15:0] base_x, base_y, off_x, off_y, lim_x, lim_y;

  logic        cmd_wr, soft_reset, fifo_push, fifo_pop, fifo_full;
  logic [31:0] head;
  logic [3:0]  head_op;
  logic [7:0]  head_cx, head_cy;
  logic [1:0]  head_idx;
  logic        in_range;
  logic [15:0] cell_colour;
  logic        col_wrap, last_px;
  logic [15:0] nxt_off_x, nxt_off_y, ld_x, ld_y, ld_colour;
  logic [31:0] ld_addr;
  logic        unused_ok;

  assign cmd_wr          = hps_write && (hps_address == 4'd0);
  assign soft_reset      = cmd_wr && (hps_writedata[31:28] == OP_SOFT);
  assign fifo_full       = (count == FULL_CNT);
  assign hps_waitrequest = cmd_wr && fifo_full && (hps_writedata[31:28] != OP_SOFT);
  assign fifo_push       = cmd_wr && !soft_reset && !fifo_full;
  assign fifo_pop        = !soft_reset && (count != '0) &&
                           ((state == WAITING) || (state == PLAYING));

  assign head     = fifo_mem[rd_ptr];
  assign head_op  = head[31:28];
  assign head_cy  = head[23:16];
  assign head_cx  = head[15:8];
  assign head_idx = head[1:0];
  assign unused_ok = ^{hps_read, head[27:24]};

  assign state_export = state;
  assign score_out    = score;

  // Command decode and next-pixel generation for the pixel engine
  always_comb begin
    in_range    = (head_cx < GRID_W8) && (head_cy < GRID_H8);
    cell_colour = (head_op == OP_FILL) ? pal[head_idx]
                : ((head_cx[0] ^ head_cy[0]) ? bg_b : bg_a);
    col_wrap    = (off_x == lim_x);
    last_px     = col_wrap && (off_y == lim_y);
    nxt_off_x   = col_wrap ? '0 : off_x + 16'd1;
    nxt_off_y   = col_wrap ? off_y + 16'd1 : off_y;
    // The first write of a block is loaded from the (zero) offsets, later ones from the advanced offsets
    ld_x        = vga_px_write ? base_x + nxt_off_x : base_x + off_x;
    ld_y        = vga_px_write ? base_y + nxt_off_y : base_y + off_y;
    ld_addr     = VGA_PX_BASE | ({16'b0, ld_y} << Y_SHIFT) | ({16'b0, ld_x} << X_SHIFT);
    ld_colour   = (state == CLEAR) ? ((ld_x[CELL_LOG2] ^ ld_y[CELL_LOG2]) ? bg_b : bg_a)
                                   : fill_colour;
  end

  // Slave read mux: status word or score
  always_comb begin
    hps_readdata = '0;
    case (hps_address)
      4'd0:    hps_readdata = {err, 13'b0, state, 16'(count)};
      4'd5:    hps_readdata = {16'b0, score};
      default: hps_readdata = '0;
    endcase
  end

  // Command FIFO storage
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= hps_writedata;
  end

  // Command FIFO pointers and occupancy; soft reset flushes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (fifo_push && !fifo_pop)      count <= count + 1'b1;
      else if (fifo_pop && !fifo_push) count <= count - 1'b1;
    end
  end

  // Palette registers, writable in any state and kept across soft reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pal[0] <= 16'h07E0;
      pal[1] <= 16'hF800;
      pal[2] <= 16'hFEA0;
      pal[3] <= 16'h001F;
      bg_a   <= 16'h8410;
      bg_b   <= 16'h0000;
    end else if (hps_write) begin
      case (hps_address)
        4'd1:    pal[0] <= hps_writedata[15:0];
        4'd2:    pal[1] <= hps_writedata[15:0];
        4'd3:    pal[2] <= hps_writedata[15:0];
        4'd4:    pal[3] <= hps_writedata[15:0];
        4'd8:    bg_a   <= hps_writedata[15:0];
        4'd9:    bg_b   <= hps_writedata[15:0];
        default: ;
      endcase
    end
  end

  // Game FSM and pixel engine with registered Avalon master outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= WAITING;
      ret_state        <= WAITING;
      score            <= '0;
      err              <= 1'b0;
      fill_colour      <= '0;
      base_x           <= '0;
      base_y           <= '0;
      off_x            <= '0;
      off_y            <= '0;
      lim_x            <= '0;
      lim_y            <= '0;
      vga_px_write     <= 1'b0;
      vga_px_address   <= '0;
      vga_px_writedata <= '0;
    end else if (soft_reset) begin
      state        <= WAITING;
      vga_px_write <= 1'b0;
      score        <= '0;
      err          <= 1'b0;
    end else begin
      case (state)
        WAITING: begin
          if (fifo_pop && head_op == OP_START) begin
            state     <= CLEAR;
            ret_state <= PLAYING;
            base_x    <= '0;
            base_y    <= '0;
            off_x     <= '0;
            off_y     <= '0;
            lim_x     <= CLR_X_LAST;
            lim_y     <= CLR_Y_LAST;
          end
        end
        PLAYING: begin
          if (fifo_pop) begin
            case (head_op)
              OP_END:   state <= WAITING;
              OP_SCORE: score <= head[15:0];
              OP_FILL, OP_ERASE: begin
                if (in_range) begin
                  state       <= FILL;
                  base_x      <= 16'({8'b0, head_cx} << CELL_LOG2);
                  base_y      <= 16'({8'b0, head_cy} << CELL_LOG2);
                  off_x       <= '0;
                  off_y       <= '0;
                  lim_x       <= CELL_LAST;
                  lim_y       <= CELL_LAST;
                  fill_colour <= cell_colour;
                end else begin
                  err <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        FILL, CLEAR: begin
          if (!vga_px_write || !vga_px_waitrequest) begin
            if (vga_px_write && last_px) begin
              vga_px_write <= 1'b0;
              state        <= (state == CLEAR) ? ret_state : PLAYING;
            end else begin
              vga_px_write     <= 1'b1;
              vga_px_address   <= ld_addr;
              vga_px_writedata <= ld_colour;
              if (vga_px_write) begin
                off_x <= nxt_off_x;
                off_y <= nxt_off_y;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_tile_renderer.sv
// Self-checking bench for snake_tile_renderer: a command-level model predicts
// the ordered list of pixel writes; a negedge monitor checks every accepted
// write and stall stability, directed checks cover registers and status.
module tb_snake_tile_renderer;

  localparam int GW  = 6;
  localparam int GH  = 4;
  localparam int CL  = 3;
  localparam int CPX = 8;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'h0800_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  hps_address;
  logic        hps_read, hps_write;
  logic [31:0] hps_writedata, hps_readdata;
  logic        hps_waitrequest;
  logic [31:0] vga_px_address;
  logic        vga_px_write;
  logic [15:0] vga_px_writedata;
  logic        vga_px_waitrequest;
  logic [1:0]  state_export;
  logic [15:0] score_out;

  snake_tile_renderer #(
    .GRID_W(GW), .GRID_H(GH), .CELL_LOG2(CL), .FIFO_DEPTH(DEPTH),
    .VGA_PX_BASE(BASE), .X_SHIFT(1), .Y_SHIFT(10)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .hps_address(hps_address), .hps_read(hps_read), .hps_write(hps_write),
    .hps_writedata(hps_writedata), .hps_readdata(hps_readdata),
    .hps_waitrequest(hps_waitrequest),
    .vga_px_address(vga_px_address), .vga_px_write(vga_px_write),
    .vga_px_writedata(vga_px_writedata), .vga_px_waitrequest(vga_px_waitrequest),
    .state_export(state_export), .score_out(score_out)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [15:0] data; } px_t;
  px_t exp_q[$];
  px_t log_q[$];
  int  checks = 0;
  int  errors = 0;
  int  stall_cnt = 0;
  bit  stall_mode = 0;
  bit  prev_stall = 0;
  px_t held;

  logic [15:0] m_pal [4];
  logic [15:0] m_bga, m_bgb, m_score;
  bit          m_playing, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_hw_reset();
    m_pal[0] = 16'h07E0; m_pal[1] = 16'hF800; m_pal[2] = 16'hFEA0; m_pal[3] = 16'h001F;
    m_bga = 16'h8410; m_bgb = 16'h0000;
    m_score = 0; m_playing = 0; m_err = 0;
    exp_q.delete();
  endtask

  function automatic void push_px(int x, int y, logic [15:0] c);
    px_t p;
    p.addr = BASE + 32'(y * 1024 + x * 2);
    p.data = c;
    exp_q.push_back(p);
  endfunction

  // Game semantics applied in command order; pixel writes are appended to exp_q.
  task automatic model_cmd(input logic [31:0] d);
    int op, cx, cy, idx;
    logic [15:0] c;
    op = int'(d[31:28]); cy = int'(d[23:16]); cx = int'(d[15:8]); idx = int'(d[1:0]);
    if (op == 15) begin
      exp_q.delete(); m_playing = 0; m_score = 0; m_err = 0;
    end else if (!m_playing) begin
      if (op == 1) begin
        for (int y = 0; y < GH * CPX; y++)
          for (int x = 0; x < GW * CPX; x++)
            push_px(x, y, (((x / CPX) + (y / CPX)) % 2 == 0) ? m_bga : m_bgb);
        m_playing = 1;
      end
    end else begin
      case (op)
        2: m_playing = 0;
        5: m_score = d[15:0];
        3, 4: begin
          if (cx < GW && cy < GH) begin
            c = (op == 3) ? m_pal[idx] : (((cx + cy) % 2 == 0) ? m_bga : m_bgb);
            for (int oy = 0; oy < CPX; oy++)
              for (int ox = 0; ox < CPX; ox++)
                push_px(cx * CPX + ox, cy * CPX + oy, c);
          end else begin
            m_err = 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, output int stalls);
    stalls = 0;
    hps_address = a; hps_writedata = d; hps_write = 1'b1;
    #1;
    while (hps_waitrequest && stalls < 4000) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (stalls >= 4000) begin
      checks++; errors++;
      $display("FAIL bus_write_timeout: got waitrequest stuck required release");
    end
    @(posedge clk); #1;
    hps_write = 1'b0;
    case (a)
      4'd0: model_cmd(d);
      4'd1, 4'd2, 4'd3, 4'd4: m_pal[int'(a) - 1] = d[15:0];
      4'd8: m_bga = d[15:0];
      4'd9: m_bgb = d[15:0];
      default: ;
    endcase
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    int s;
    bus_write(a, d, s);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    hps_address = a; hps_read = 1'b1;
    #2;
    d = hps_readdata;
    hps_read = 1'b0;
  endtask

  task automatic wait_idle(input logic [1:0] exp_state);
    int n = 0;
    while ((exp_q.size() != 0 || vga_px_write) && n < 20000) begin
      tick(); n++;
    end
    chk("drain_remaining", exp_q.size(), 0);
    tick(); tick();
    chk("idle_state", state_export, exp_state);
  endtask

  // Pixel-master slave model: optional 3-cycle stall on every pixel
  initial begin
    int phase = 0;
    vga_px_waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_mode && vga_px_write) begin
        vga_px_waitrequest = (phase != 3);
        phase = (phase + 1) % 4;
      end else begin
        vga_px_waitrequest = 1'b0;
        phase = 0;
      end
    end
  end

  // Compare process: every accepted pixel write against the model, stalls held stable
  always @(negedge clk) begin
    px_t e;
    if (!reset_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_write", vga_px_write, 1'b1);
        chk("hold_addr", vga_px_address, held.addr);
        chk("hold_data", vga_px_writedata, held.data);
      end
      if (vga_px_write && !vga_px_waitrequest) begin
        log_q.push_back({vga_px_address, vga_px_writedata});
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_write: got write addr %h data %h required none", vga_px_address, vga_px_writedata);
        end else begin
          e = exp_q.pop_front();
          chk("px_addr", vga_px_address, e.addr);
          chk("px_data", vga_px_writedata, e.data);
        end
      end
      if (vga_px_write && vga_px_waitrequest) stall_cnt++;
      prev_stall = vga_px_write && vga_px_waitrequest;
      held = {vga_px_address, vga_px_writedata};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int s, n;
    reset_n = 1'b0; hps_address = '0; hps_read = 0; hps_write = 0; hps_writedata = '0;
    model_hw_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write", vga_px_write, 1'b0);
    chk("rst_addr", vga_px_address, 32'h0);
    chk("rst_data", vga_px_writedata, 16'h0);
    chk("rst_state", state_export, 2'd0);
    chk("rst_score", score_out, 16'd0);
    chk("rst_waitreq", hps_waitrequest, 1'b0);
    bus_read(4'd0, rd); chk("rst_status", rd, 32'h0);
    reset_n = 1'b1;
    tick();

    // START + FILL(2,1,P1): checkerboard clear then one cell
    log_q.delete();
    wr(4'd2, 32'h0000_1234);
    wr(4'd0, 32'h1000_0000);
    wr(4'd0, 32'h3001_0201);
    chk("lat_state_clear", state_export, 2'd3);
    chk("lat_write_low", vga_px_write, 1'b0);
    tick();
    chk("lat_write_high", vga_px_write, 1'b1);
    chk("lat_first_addr", vga_px_address, 32'h0800_0000);
    chk("lat_first_data", vga_px_writedata, 16'h8410);
    wait_idle(2'd1);
    chk("p1_count", log_q.size(), 1600);
    chk("p1_clr_x8_data", log_q[8].data, 16'h0000);
    chk("p1_clr_x8_addr", log_q[8].addr, 32'h0800_0010);
    chk("p1_clr_y8_addr", log_q[384].addr, 32'h0800_2000);
    chk("p1_fill_first_addr", log_q[1536].addr, 32'h0800_2020);
    chk("p1_fill_first_data", log_q[1536].data, 16'h1234);
    chk("p1_fill_last_addr", log_q[1599].addr, 32'h0800_3C2E);

    // ERASE(3,0) with 3 stall cycles per pixel
    log_q.delete(); stall_cnt = 0; stall_mode = 1;
    wr(4'd0, 32'h4000_0300);
    wait_idle(2'd1);
    stall_mode = 0;
    chk("erase_count", log_q.size(), 64);
    chk("erase_first_addr", log_q[0].addr, 32'h0800_0030);
    chk("erase_first_data", log_q[0].data, 16'h0000);
    chk("erase_stalls", stall_cnt, 192);

    // Out-of-range cells set sticky err; SCORE loads
    log_q.delete();
    wr(4'd0, 32'h3000_0600);
    wr(4'd0, 32'h3004_0000);
    repeat (4) tick();
    chk("oor_no_writes", log_q.size(), 0);
    bus_read(4'd0, rd); chk("oor_status", rd, 32'h8001_0000);
    wr(4'd0, 32'h5000_004D);
    repeat (3) tick();
    bus_read(4'd5, rd); chk("score_read", rd, 32'd77);
    chk("score_out", score_out, 16'd77);

    // FIFO fills during CLEAR; 9th push stalls until first pop
    log_q.delete();
    wr(4'd0, 32'h2000_0000);
    wr(4'd0, 32'h1000_0000);
    for (int i = 0; i < 8; i++)
      wr(4'd0, 32'h3000_0000 | ((i % GH) << 16) | ((i % GW) << 8) | (i % 4));
    bus_read(4'd0, rd); chk("full_status", rd, 32'h8003_0008);
    bus_write(4'd0, 32'h3000_0200, s);
    chk("ninth_push_stalled", s > 1000, 1'b1);
    wait_idle(2'd1);
    chk("full_phase_count", log_q.size(), 1536 + 9 * 64);

    // SOFT_RESET while full is never stalled and flushes everything
    wr(4'd0, 32'h2000_0000);
    wr(4'd0, 32'h1000_0000);
    for (int i = 0; i < 8; i++)
      wr(4'd0, 32'h3000_0000 | (i << 8) | 32'h1);
    bus_read(4'd0, rd); chk("full2_status", rd, 32'h8003_0008);
    bus_write(4'd0, 32'hF000_0000, s);
    chk("soft_no_stall", s, 0);
    chk("soft_write_low", vga_px_write, 1'b0);
    chk("soft_score", score_out, 16'd0);
    bus_read(4'd0, rd); chk("soft_status", rd, 32'h0);
    repeat (10) tick();
    chk("soft_state", state_export, 2'd0);

    // WAITING discards everything but START
    log_q.delete();
    wr(4'd0, 32'h3000_0000);
    wr(4'd0, 32'h5000_0005);
    repeat (4) tick();
    chk("wait_score", score_out, 16'd0);
    chk("wait_no_writes", log_q.size(), 0);
    bus_read(4'd0, rd); chk("wait_status", rd, 32'h0);
    wr(4'd0, 32'h1000_0000);
    tick();
    chk("wait_start_clear", state_export, 2'd3);
    wr(4'd0, 32'h3000_0001);
    n = 0;
    while (!(state_export == 2'd2 && vga_px_write) && n < 4000) begin tick(); n++; end
    chk("reach_fill", n < 4000, 1'b1);
    repeat (5) tick();
    chk("soft_kept_palette", log_q[1536].data, 16'h1234);

    // Asynchronous reset mid-FILL
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_write_low", vga_px_write, 1'b0);
    model_hw_reset();
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_state", state_export, 2'd0);
    bus_read(4'd0, rd); chk("post_rst_status", rd, 32'h0);

    // Palette back at defaults
    log_q.delete();
    wr(4'd0, 32'h1000_0000);
    wr(4'd0, 32'h3001_0100);
    wr(4'd0, 32'h3003_0501);
    wait_idle(2'd1);
    chk("def_count", log_q.size(), 1536 + 128);
    chk("def_p0", log_q[1536].data, 16'h07E0);
    chk("def_p1", log_q[1600].data, 16'hF800);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
